// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: opcodes, FSM state encoding and instruction field positions
package regfile_seq_pkg;
    localparam int INSTR_W = 13;
    localparam int OP_LSB  = 10;
    localparam int DST_LSB = 8;
    localparam int A_LSB   = 6;
    localparam int B_LSB   = 4;
    localparam int IMM_LSB = 0;
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDI = 3'd1;
    localparam logic [2:0] OP_MOV = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_OUT = 3'd7;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_OUT} state_e;
endpackage

// File: rtl/seq_alu.sv
// seq_alu: combinational ALU producing the write-back value and carry/borrow
module seq_alu import regfile_seq_pkg::*; #(
    parameter int DATA_W = 4
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] y,
    output logic              c
);
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        y = op == OP_LDI ? imm :
            op == OP_ADD ? sum[DATA_W-1:0] :
            op == OP_SUB ? diff[DATA_W-1:0] :
            op == OP_AND ? a & b :
            op == OP_XOR ? a ^ b : a;
        c = op == OP_ADD ? sum[DATA_W] : op == OP_SUB ? diff[DATA_W] : 1'b0;
    end
endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: fetches one instruction per handshake, reads operands from the
// register file, writes back the ALU result or returns a value on the result port
module regfile_sequencer import regfile_seq_pkg::*; #(
    parameter int DATA_W = 4,
    parameter int SEL_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               rf_load_en,
    output logic [DATA_W-1:0]  rf_d,
    output logic [SEL_W-1:0]   rf_dest_sel,
    output logic [SEL_W-1:0]   rf_a_sel,
    output logic [SEL_W-1:0]   rf_b_sel,
    input  logic [DATA_W-1:0]  rf_a,
    input  logic [DATA_W-1:0]  rf_b,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [DATA_W-1:0]  result,
    output logic               flag_z,
    output logic               flag_c,
    output logic               busy
);
    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]    opa_q, opa_d, opb_q, opb_d;
    logic                 flag_z_q, flag_z_d, flag_c_q, flag_c_d;
    logic [2:0]           op;
    logic [DATA_W-1:0]    alu_y;
    logic                 alu_c;

    assign op           = instr_q[OP_LSB +: 3];
    assign rf_a_sel     = instr_q[A_LSB +: SEL_W];
    assign rf_b_sel     = instr_q[B_LSB +: SEL_W];
    assign rf_dest_sel  = instr_q[DST_LSB +: SEL_W];
    assign rf_d         = alu_y;
    assign rf_load_en   = state_q == S_WRITE;
    assign instr_ready  = state_q == S_IDLE;
    assign busy         = state_q != S_IDLE;
    assign result_valid = state_q == S_OUT;
    assign result       = opa_q;
    assign flag_z       = flag_z_q;
    assign flag_c       = flag_c_q;

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op  (op),
        .a   (opa_q),
        .b   (opb_q),
        .imm (instr_q[IMM_LSB +: DATA_W]),
        .y   (alu_y),
        .c   (alu_c)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        case (state_q)
            S_IDLE: if (instr_valid) begin
                instr_d = instr;
                state_d = instr[OP_LSB +: 3] == OP_NOP ? S_IDLE : S_READ;
            end
            S_READ: begin
                opa_d   = rf_a;
                opb_d   = rf_b;
                state_d = op == OP_OUT ? S_OUT : S_WRITE;
            end
            S_WRITE: begin
                flag_z_d = alu_y == '0;
                flag_c_d = (op == OP_ADD || op == OP_SUB) ? alu_c : flag_c_q;
                state_d  = S_IDLE;
            end
            default: state_d = result_ready ? S_IDLE : S_OUT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: sequencer with a behavioural 4x4 register file; directed table,
// hand-written corner sequences and random instructions checked against a reference model
module tb_regfile_sequencer;
    import regfile_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [12:0] instr = '0;
    logic        rf_load_en;
    logic [3:0]  rf_d;
    logic [1:0]  rf_dest_sel, rf_a_sel, rf_b_sel;
    logic [3:0]  rf_a, rf_b;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [3:0]  result;
    logic        flag_z, flag_c, busy;

    logic [3:0]  mem [4];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          rr [4];
    int          rz = 0, rc = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] dst, a, b;
        logic [3:0] imm, exp;
        logic       ez, ec;
        logic [1:0] stall;
    } vec_t;
    vec_t tbl [16];

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_load_en) mem[rf_dest_sel] <= rf_d;
    assign rf_a = mem[rf_a_sel];
    assign rf_b = mem[rf_b_sel];

    regfile_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rf_load_en(rf_load_en), .rf_d(rf_d), .rf_dest_sel(rf_dest_sel),
        .rf_a_sel(rf_a_sel), .rf_b_sel(rf_b_sel), .rf_a(rf_a), .rf_b(rf_b),
        .result_valid(result_valid), .result_ready(result_ready), .result(result),
        .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        else pass_cnt++;
    endtask

    // Architectural model: register values and flags from the opcode definitions alone
    function automatic void ref_exec(input logic [2:0] op, input int d, input int a,
                                     input int b, input int imm, output int exp);
        int v;
        exp = 0;
        v = 0;
        case (op)
            OP_LDI: v = imm;
            OP_MOV: v = rr[a];
            OP_ADD: begin v = (rr[a] + rr[b]) % 16; rc = (rr[a] + rr[b] > 15) ? 1 : 0; end
            OP_SUB: begin v = (rr[a] - rr[b] + 16) % 16; rc = (rr[a] < rr[b]) ? 1 : 0; end
            OP_AND: v = rr[a] & rr[b];
            OP_XOR: v = rr[a] ^ rr[b];
            OP_OUT: exp = rr[a];
            default: ;
        endcase
        if (op != OP_NOP && op != OP_OUT) begin
            rr[d] = v;
            rz = (v == 0) ? 1 : 0;
            exp = v;
        end
    endfunction

    task automatic run(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] a,
                       input logic [1:0] b, input logic [3:0] imm, input logic [3:0] exp,
                       input logic ez, input logic ec, input int stall);
        int n;
        @(negedge clk);
        instr = {op, dst, a, b, imm};
        instr_valid = 1'b1;
        result_ready = (op != OP_OUT) ? 1'($urandom_range(0, 1)) : 1'b0;
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept_in_time", n < 20, 1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 13'($urandom);
        @(negedge clk);
        if (op == OP_NOP) begin
            chk("nop_busy", busy, 0);
            chk("nop_load", rf_load_en, 0);
            chk("nop_ready", instr_ready, 1);
        end else begin
            chk("read_ready", instr_ready, 0);
            chk("read_load", rf_load_en, 0);
            chk("read_rv", result_valid, 0);
            @(negedge clk);
            if (op == OP_OUT) begin
                chk("out_valid", result_valid, 1);
                chk("out_data", result, exp);
                for (int i = 0; i < stall; i++) begin
                    @(negedge clk);
                    chk("out_hold_valid", result_valid, 1);
                    chk("out_hold_data", result, exp);
                end
                result_ready = 1'b1;
                @(negedge clk);
                chk("out_done", result_valid, 0);
                chk("out_ready", instr_ready, 1);
            end else begin
                chk("wr_load", rf_load_en, 1);
                chk("wr_busy", busy, 1);
                chk("wr_dest", rf_dest_sel, dst);
                chk("wr_data", rf_d, exp);
                @(negedge clk);
                chk("wr_reg", mem[dst], exp);
                chk("wr_load_off", rf_load_en, 0);
                chk("wr_ready", instr_ready, 1);
            end
        end
        chk("flag_z", flag_z, ez);
        chk("flag_c", flag_c, ec);
        result_ready = 1'b0;
    endtask

    logic [2:0] r_op;
    logic [1:0] r_d, r_a, r_b;
    logic [3:0] r_imm;
    int         e;

    initial begin
        tbl[0]  = '{OP_LDI, 2'd2, 2'd0, 2'd0, 4'd9,  4'd9,  1'b0, 1'b0, 2'd0};
        tbl[1]  = '{OP_OUT, 2'd0, 2'd2, 2'd0, 4'd0,  4'd9,  1'b0, 1'b0, 2'd3};
        tbl[2]  = '{OP_LDI, 2'd0, 2'd0, 2'd0, 4'd12, 4'd12, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{OP_LDI, 2'd1, 2'd0, 2'd0, 4'd7,  4'd7,  1'b0, 1'b0, 2'd0};
        tbl[4]  = '{OP_ADD, 2'd3, 2'd0, 2'd1, 4'd0,  4'd3,  1'b0, 1'b1, 2'd0};
        tbl[5]  = '{OP_OUT, 2'd0, 2'd3, 2'd0, 4'd0,  4'd3,  1'b0, 1'b1, 2'd1};
        tbl[6]  = '{OP_SUB, 2'd3, 2'd1, 2'd1, 4'd0,  4'd0,  1'b1, 1'b0, 2'd0};
        tbl[7]  = '{OP_SUB, 2'd2, 2'd1, 2'd0, 4'd0,  4'd11, 1'b0, 1'b1, 2'd0};
        tbl[8]  = '{OP_LDI, 2'd0, 2'd0, 2'd0, 4'd0,  4'd0,  1'b1, 1'b1, 2'd0};
        tbl[9]  = '{OP_NOP, 2'd3, 2'd1, 2'd2, 4'd5,  4'd0,  1'b1, 1'b1, 2'd0};
        tbl[10] = '{OP_LDI, 2'd0, 2'd0, 2'd0, 4'd12, 4'd12, 1'b0, 1'b1, 2'd0};
        tbl[11] = '{OP_AND, 2'd3, 2'd0, 2'd1, 4'd0,  4'd4,  1'b0, 1'b1, 2'd0};
        tbl[12] = '{OP_XOR, 2'd2, 2'd0, 2'd1, 4'd0,  4'd11, 1'b0, 1'b1, 2'd0};
        tbl[13] = '{OP_MOV, 2'd0, 2'd2, 2'd0, 4'd0,  4'd11, 1'b0, 1'b1, 2'd0};
        tbl[14] = '{OP_OUT, 2'd0, 2'd0, 2'd0, 4'd0,  4'd11, 1'b0, 1'b1, 2'd0};
        tbl[15] = '{OP_ADD, 2'd1, 2'd1, 2'd1, 4'd0,  4'd14, 1'b0, 1'b0, 2'd0};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_load", rf_load_en, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_z, flag_c}, 0);
        chk("rst_sel", {rf_a_sel, rf_b_sel, rf_dest_sel}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            ref_exec(tbl[i].op, int'(tbl[i].dst), int'(tbl[i].a), int'(tbl[i].b), int'(tbl[i].imm), e);
            run(tbl[i].op, tbl[i].dst, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].exp,
                tbl[i].ez, tbl[i].ec, int'(tbl[i].stall));
        end

        // Back-to-back: valid held high, second instruction waits for IDLE
        @(negedge clk);
        chk("b2b_idle", instr_ready, 1);
        instr = {OP_LDI, 2'd1, 2'd0, 2'd0, 4'd5};
        instr_valid = 1'b1;
        ref_exec(OP_LDI, 1, 0, 0, 5, e);
        @(posedge clk);
        #1 instr = {OP_MOV, 2'd0, 2'd1, 2'd0, 4'd0};
        @(negedge clk);
        chk("b2b_read_rdy", instr_ready, 0);
        @(negedge clk);
        chk("b2b_write_rdy", instr_ready, 0);
        chk("b2b_write_load", rf_load_en, 1);
        @(negedge clk);
        chk("b2b_idle_rdy", instr_ready, 1);
        chk("b2b_r1", mem[1], 5);
        ref_exec(OP_MOV, 0, 1, 0, 0, e);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_mov_load", rf_load_en, 1);
        chk("b2b_mov_dest", rf_dest_sel, 0);
        chk("b2b_mov_data", rf_d, 5);
        @(negedge clk);
        chk("b2b_r0", mem[0], 5);
        chk("b2b_z", flag_z, rz[0]);
        chk("b2b_c", flag_c, rc[0]);

        // Reset during WRITE: enable drops at once and the write is lost
        ref_exec(OP_LDI, 2, 0, 0, 0, e);
        run(OP_LDI, 2'd2, 2'd0, 2'd0, 4'd0, 4'd0, 1'b1, rc[0], 0);
        @(negedge clk);
        instr = {OP_ADD, 2'd3, 2'd0, 2'd1, 4'd0};
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_load_pre", rf_load_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_load", rf_load_en, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", instr_ready, 1);
        chk("mid_flags", {flag_z, flag_c}, 0);
        chk("mid_asel", rf_a_sel, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_reg_kept", mem[3], rr[3]);
        rst_n = 1'b1;
        rz = 0;
        rc = 0;

        for (int i = 0; i < 150; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_d = 2'($urandom);
            r_a = 2'($urandom);
            r_b = 2'($urandom);
            r_imm = 4'($urandom);
            ref_exec(r_op, int'(r_d), int'(r_a), int'(r_b), int'(r_imm), e);
            run(r_op, r_d, r_a, r_b, r_imm, 4'(e), rz[0], rc[0], $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
